// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory-access stage.
package lc3_mem_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_ACC,
    S_RESP
  } state_e;

  function automatic logic is_store(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic is_indirect(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// LC-3 memory-access stage: one LD/ST/LDI/STI at a time, variable-latency
// memory port with acknowledge, watchdog abort, registered response.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          dmem_en,
  output logic          dmem_rd,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_din,
  input  logic [DW-1:0] dmem_dout,
  input  logic          dmem_ack,
  output logic          busy
);

  localparam int WD_W = $clog2(MAX_WAIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_WAIT - 1);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            store_q, store_d;
  logic            en_q, en_d;
  logic            rd_q, rd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dmem_en   = en_q;
  assign dmem_rd   = rd_q;
  assign dmem_addr = addr_q;
  assign dmem_din  = din_q;
  assign busy      = busy_q;

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      store_q     <= 1'b0;
      en_q        <= 1'b0;
      rd_q        <= MEM_READ;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      store_q     <= store_d;
      en_q        <= en_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output decode; everything holds unless changed here.
  // Store data is loaded into din at accept so it is already stable through
  // the pointer read of an STI, and doubles as the store response value.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    store_d     = store_q;
    en_d        = en_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d   = is_store(req_op);
          en_d      = 1'b1;
          addr_d    = req_addr;
          wd_d      = '0;
          rsp_err_d = 1'b0;
          if (is_store(req_op)) din_d = req_data;
          if (is_indirect(req_op)) begin
            state_d = S_PTR;
            rd_d    = MEM_READ;
          end else begin
            state_d = S_ACC;
            rd_d    = is_store(req_op) ? MEM_WRITE : MEM_READ;
          end
        end
      end
      S_PTR: begin
        if (dmem_ack) begin
          state_d = S_ACC;
          addr_d  = AW'(dmem_dout);
          rd_d    = store_q ? MEM_WRITE : MEM_READ;
          wd_d    = '0;
        end else if (wd_q == WD_LAST) begin
          state_d     = S_RESP;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          wd_d        = wd_q + WD_W'(1);
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ACC: begin
        if (dmem_ack) begin
          state_d     = S_RESP;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = store_q ? din_q : dmem_dout;
        end else if (wd_q == WD_LAST) begin
          state_d     = S_RESP;
          en_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          wd_d        = wd_q + WD_W'(1);
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small latency-programmable memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic        dmem_en, dmem_rd, dmem_ack;
  logic [15:0] dmem_addr, dmem_din, dmem_dout;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Sparse memory: one word per 4 KiB page, indexed by address[15:12].
  logic [15:0] mem [16];
  int          lat;
  bit          ack_on;
  int          wcnt;
  logic [15:0] wr_addr, wr_data;

  mem_access_ctrl #(.DW(16), .AW(16), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .dmem_en(dmem_en), .dmem_rd(dmem_rd), .dmem_addr(dmem_addr),
    .dmem_din(dmem_din), .dmem_dout(dmem_dout), .dmem_ack(dmem_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    dmem_ack  = dmem_en && ack_on && (wcnt == lat);
    dmem_dout = mem[dmem_addr[15:12]];
  end

  always @(posedge clk) begin
    if (!rst || !dmem_en || dmem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (rst && dmem_en && dmem_ack && !dmem_rd) begin
      wr_addr <= dmem_addr;
      wr_data <= dmem_din;
    end
  end

  // Bus must hold while strobed, except right after an ack (PTR->ACC).
  initial begin
    logic p_en, p_ack, p_rd;
    logic [15:0] p_addr, p_din;
    p_en = 1'b0; p_ack = 1'b0; p_rd = 1'b1; p_addr = '0; p_din = '0;
    forever begin
      @(negedge clk);
      if (p_en && dmem_en && !p_ack) begin
        vectors++;
        if ({dmem_addr, dmem_din, dmem_rd} !== {p_addr, p_din, p_rd}) begin
          miscompares++;
          $display("FAIL bus_stable got %h/%h/%b exp %h/%h/%b", dmem_addr, dmem_din, dmem_rd, p_addr, p_din, p_rd);
        end
      end
      p_en = dmem_en && rst; p_ack = dmem_ack;
      p_rd = dmem_rd; p_addr = dmem_addr; p_din = dmem_din;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d);
    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    vectors++; if (dmem_en !== 1'b0) begin miscompares++; $display("FAIL rst_en got %b exp 0", dmem_en); end
    vectors++; if (dmem_rd !== 1'b1) begin miscompares++; $display("FAIL rst_rd got %b exp 1", dmem_rd); end
    vectors++; if (dmem_addr !== 16'h0) begin miscompares++; $display("FAIL rst_addr got %h exp 0", dmem_addr); end
    vectors++; if (dmem_din !== 16'h0) begin miscompares++; $display("FAIL rst_din got %h exp 0", dmem_din); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    vectors++; if (rsp_data !== 16'h0) begin miscompares++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_err got %b exp 0", rsp_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b exp 0", busy); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_ld();
    int n;
    mem[3] = 16'h1234; lat = 0;
    issue(2'b00, 16'h3000, 16'h0);
    vectors++; if (dmem_en !== 1'b1) begin miscompares++; $display("FAIL ld_en got %b exp 1", dmem_en); end
    vectors++; if (dmem_rd !== 1'b1) begin miscompares++; $display("FAIL ld_rd got %b exp 1", dmem_rd); end
    vectors++; if (dmem_addr !== 16'h3000) begin miscompares++; $display("FAIL ld_addr got %h exp 3000", dmem_addr); end
    wait_rsp(n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL ld_latency got %0d exp 2", n); end
    vectors++; if (rsp_data !== 16'h1234) begin miscompares++; $display("FAIL ld_data got %h exp 1234", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL ld_err got %b exp 0", rsp_err); end
    vectors++; if (dmem_en !== 1'b0) begin miscompares++; $display("FAIL ld_en_drop got %b exp 0", dmem_en); end
    handshake();
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ld_rsp_clear got %b exp 0", rsp_valid); end
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL ld_idle got %b exp 1", req_ready); end
  endtask

  task automatic test_sti();
    mem[4] = 16'h5000; lat = 0;
    issue(2'b11, 16'h4000, 16'hBEEF);
    vectors++; if ({dmem_en, dmem_rd, dmem_addr} !== {2'b11, 16'h4000}) begin miscompares++; $display("FAIL sti_ptr got en=%b rd=%b addr=%h exp 1/1/4000", dmem_en, dmem_rd, dmem_addr); end
    step();
    vectors++; if ({dmem_en, dmem_rd, dmem_addr} !== {2'b10, 16'h5000}) begin miscompares++; $display("FAIL sti_acc got en=%b rd=%b addr=%h exp 1/0/5000", dmem_en, dmem_rd, dmem_addr); end
    vectors++; if (dmem_din !== 16'hBEEF) begin miscompares++; $display("FAIL sti_din got %h exp beef", dmem_din); end
    step();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL sti_latency got valid=%b exp 1", rsp_valid); end
    vectors++; if (rsp_data !== 16'hBEEF) begin miscompares++; $display("FAIL sti_data got %h exp beef", rsp_data); end
    vectors++; if ({wr_addr, wr_data} !== {16'h5000, 16'hBEEF}) begin miscompares++; $display("FAIL sti_write got %h=%h exp 5000=beef", wr_addr, wr_data); end
    handshake();
  endtask

  task automatic test_ldi_waits();
    int n;
    mem[3] = 16'h6000; mem[6] = 16'hCAFE; lat = 3;
    issue(2'b10, 16'h3000, 16'h0);
    wait_rsp(n);
    vectors++; if (n !== 9) begin miscompares++; $display("FAIL ldi_latency got %0d exp 9", n); end
    vectors++; if (rsp_data !== 16'hCAFE) begin miscompares++; $display("FAIL ldi_data got %h exp cafe", rsp_data); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL ldi_err got %b exp 0", rsp_err); end
    lat = 0;
    handshake();
  endtask

  task automatic test_watchdog();
    int n;
    ack_on = 1'b0;
    issue(2'b01, 16'h7000, 16'h1111);
    n = 0;
    while (dmem_en && n < 40) begin
      n++;
      step();
    end
    vectors++; if (n !== 15) begin miscompares++; $display("FAIL wd_en_cycles got %0d exp 15", n); end
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL wd_valid got %b exp 1", rsp_valid); end
    vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL wd_err got %b exp 1", rsp_err); end
    vectors++; if (rsp_data !== 16'h0) begin miscompares++; $display("FAIL wd_data got %h exp 0", rsp_data); end
    ack_on = 1'b1;
    handshake();
    issue(2'b00, 16'h3000, 16'h0);
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL wd_err_clear got %b exp 0", rsp_err); end
    wait_rsp(n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL wd_next_latency got %0d exp 2", n); end
    vectors++; if ({rsp_err, rsp_data} !== {1'b0, 16'h6000}) begin miscompares++; $display("FAIL wd_next_rsp got %b/%h exp 0/6000", rsp_err, rsp_data); end
    handshake();
  endtask

  task automatic test_ack_at_limit();
    int n;
    lat = 14;
    issue(2'b00, 16'h3000, 16'h0);
    wait_rsp(n);
    vectors++; if (n !== 16) begin miscompares++; $display("FAIL limit_ack_latency got %0d exp 16", n); end
    vectors++; if ({rsp_err, rsp_data} !== {1'b0, 16'h6000}) begin miscompares++; $display("FAIL limit_ack_rsp got %b/%h exp 0/6000", rsp_err, rsp_data); end
    handshake();
    lat = 15;
    issue(2'b00, 16'h3000, 16'h0);
    wait_rsp(n);
    vectors++; if (n !== 16) begin miscompares++; $display("FAIL late_ack_latency got %0d exp 16", n); end
    vectors++; if ({rsp_err, rsp_data} !== {1'b1, 16'h0}) begin miscompares++; $display("FAIL late_ack_rsp got %b/%h exp 1/0000", rsp_err, rsp_data); end
    handshake();
    lat = 0;
  endtask

  task automatic test_rsp_hold();
    int n;
    issue(2'b00, 16'h3000, 16'h0);
    wait_rsp(n);
    vectors++; if (n !== 2) begin miscompares++; $display("FAIL hold_latency got %0d exp 2", n); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if ({rsp_valid, rsp_data, req_ready, busy} !== {1'b1, 16'h6000, 1'b0, 1'b1}) begin
        miscompares++; $display("FAIL hold_cycle%0d got v=%b d=%h rr=%b b=%b exp 1/6000/0/1", i, rsp_valid, rsp_data, req_ready, busy);
      end
    end
    handshake();
    vectors++; if ({req_ready, busy} !== 2'b10) begin miscompares++; $display("FAIL hold_release got rr=%b b=%b exp 1/0", req_ready, busy); end
  endtask

  task automatic test_back_to_back();
    int acc;
    acc = 0;
    rsp_ready = 1'b1;
    req_op = 2'b00; req_addr = 16'h3000; req_data = 16'h0; req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    vectors++; if (acc !== 3) begin miscompares++; $display("FAIL b2b_accepts got %0d exp 3", acc); end
  endtask

  task automatic test_reset_mid();
    ack_on = 1'b0;
    issue(2'b01, 16'h7000, 16'h2222);
    step();
    vectors++; if ({busy, dmem_en} !== 2'b11) begin miscompares++; $display("FAIL mid_pre got b=%b en=%b exp 1/1", busy, dmem_en); end
    rst = 1'b0;
    step();
    vectors++; if ({dmem_en, dmem_rd, dmem_addr, dmem_din} !== {2'b01, 32'h0}) begin
      miscompares++; $display("FAIL mid_bus got en=%b rd=%b a=%h d=%h exp 0/1/0/0", dmem_en, dmem_rd, dmem_addr, dmem_din);
    end
    vectors++; if ({rsp_valid, rsp_err, rsp_data, busy} !== {2'b00, 16'h0, 1'b0}) begin
      miscompares++; $display("FAIL mid_rsp got v=%b e=%b d=%h b=%b exp 0/0/0/0", rsp_valid, rsp_err, rsp_data, busy);
    end
    rst = 1'b1;
    ack_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if ({rsp_valid, dmem_en} !== 2'b00) begin miscompares++; $display("FAIL mid_no_rsp%0d got v=%b en=%b exp 0/0", i, rsp_valid, dmem_en); end
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_data = '0;
    rsp_ready = 1'b0; ack_on = 1'b1; lat = 0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_ld();
    test_sti();
    test_ldi_waits();
    test_watchdog();
    test_ack_at_limit();
    test_rsp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Parametrised memory-access stage controller for the LC-3 datapath. It accepts one load/store request at a time from execute over a valid/ready handshake and drives the data-memory port. It supports direct (LD/ST) and indirect (LDI/STI) accesses, handles variable memory latency through an acknowledge, and aborts stalled accesses with a watchdog. Results go to writeback over a valid/ready response handshake.

## Interface
- DW, 16, data width in bits
- AW, 16, address width in bits
- MAX_WAIT, 15, maximum cycles `dmem_en` may stay high without `dmem_ack` before abort (must be ≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (high only in IDLE)
- req_op  in  2  00 LD, 01 ST, 10 LDI, 11 STI
- req_addr  in  AW  effective address
- req_data  in  DW  store data
- rsp_valid  out  1  response present
- rsp_ready  in  1  writeback accepts the response
- rsp_data  out  DW  load result, or the stored data for ST/STI
- rsp_err  out  1  access aborted by watchdog; qualified by `rsp_valid`
- dmem_en  out  1  memory access strobe
- dmem_rd  out  1  1 = read, 0 = write
- dmem_addr  out  AW  memory address
- dmem_din  out  DW  write data to memory
- dmem_dout  in  DW  read data from memory, valid in the cycle `dmem_ack` is high
- dmem_ack  in  1  access complete; ignored when `dmem_en` is low
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, PTR, ACC, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, capture op, addr and data.
  - LD/ST go to ACC. LDI/STI go to PTR.
- PTR:
  - Read at the captured address.
  - On ack, the pointer is `dmem_dout[AW-1:0]`, zero-extended when DW < AW. Go to ACC using the pointer as the address.
- ACC:
  - Read for LD/LDI, or write of the captured data for ST/STI.
  - On ack, capture `rsp_data`: `dmem_dout` for loads, the captured data for stores. Go to RESP.
- RESP:
  - `rsp_valid` = 1, holding `rsp_data` and `rsp_err` stable.
  - On `rsp_ready`, go to IDLE.
- Watchdog:
  - The counter clears on every entry to PTR or ACC and increments each cycle without ack.
  - If it reaches MAX_WAIT with no ack, drop `dmem_en`, set `rsp_err` = 1 and `rsp_data` = 0, and go to RESP.
  - An ack in the same cycle the counter reaches MAX_WAIT wins; no error is raised.
- `rsp_err` clears on entry to PTR for the next request, or on entry to ACC for a direct request.
- Bus stability: while `dmem_en` = 1, `dmem_addr`, `dmem_din` and `dmem_rd` must not change.
- Between PTR and ACC, `dmem_en` stays high. Address and direction change at that edge.
- Reset values: `dmem_en` 0, `dmem_rd` 1, `dmem_addr` 0, `dmem_din` 0, `rsp_valid` 0, `rsp_data` 0, `rsp_err` 0, `busy` 0, state IDLE, watchdog 0.
- Reset mid-operation aborts the access: all outputs return to reset values at that edge and no response is produced.

## Timing
- All outputs are registered; no combinational path from inputs to outputs except `req_ready`, which is decoded from state.
- Accept at edge 0 → `dmem_en` high in cycle 1.
- With ack in cycle 1, `rsp_valid` is high in cycle 2.
- LD/ST minimum latency, request-accept to `rsp_valid`: 2 cycles. LDI/STI minimum: 3 cycles.
- Each cycle without ack adds one cycle of latency.
- Back-to-back throughput: one request accepted per (latency + 1) cycles at best. IDLE follows the RESP handshake before the next accept.

## Structure
- Shared package `lc3_mem_pkg` holds:
  - op encodings (OP_LD/OP_ST/OP_LDI/OP_STI)
  - MEM_READ = 1'b1 and MEM_WRITE = 1'b0
  - the state enum type
- Single module; the watchdog is an inline counter of width `$clog2(MAX_WAIT+1)`. No sub-module.

## Test plan
- LD, addr 0x3000, memory returns 0x1234 with ack in the first cycle → `rsp_valid` in cycle 2, `rsp_data` 0x1234, `rsp_err` 0, `dmem_rd` 1.
- STI, addr 0x4000, mem[0x4000] = 0x5000, data 0xBEEF → PTR read of 0x4000, then write of 0xBEEF to 0x5000 with `dmem_rd` 0; `rsp_data` 0xBEEF.
- LDI with 3 wait cycles on each access → `rsp_valid` at cycle 9; addr/din/rd stable throughout every `dmem_en` window.
- ST with ack never asserted, MAX_WAIT = 15 → `dmem_en` drops after 15 cycles; `rsp_err` 1, `rsp_data` 0; the next LD completes with `rsp_err` 0.
- Ack arrives exactly at the MAX_WAIT-th wait cycle → normal completion, `rsp_err` 0.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid` and data held, `req_ready` 0; reset asserted mid-ACC → next cycle all outputs at reset values and no response issued.
